frame_capture_ctrl: RTL
=======================

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter H, default 752, meaning pixels per line.
REQ-002 SHALL have parameter V, default 480, meaning lines per frame.
REQ-003 SHALL have port CLK, input, 1, pixel clock; all logic is in this single clock domain.
REQ-004 SHALL have port RST, input, 1, reset (asynchronous, active-high).
REQ-005 SHALL have ports FRAME_VALID, LINE_VALID (input, 1) and DATA_IN (input, 10): sensor sync and pixel data.
REQ-006 SHALL have ports START (input, 1, arm request), CONTINUOUS (input, 1, re-arm after each frame) and ABORT (input, 1, cancel).
REQ-007 SHALL have ports WR_EN (output, 1), WR_ADDR (output, $clog2(H*V)), WR_DATA (output, 10) and WR_READY (input, 1): frame-buffer write port.
REQ-008 SHALL have ports BUSY (output, 1), DONE (output, 1, one-cycle pulse), OVERFLOW (output, 1, sticky) and PIX_COUNT (output, $clog2(H*V+1), pixels accepted in last frame).

Function
REQ-009 SHALL implement states IDLE, SYNC, WAIT_SOF and CAPTURE.
REQ-010 IDLE: START=1 SHALL move to SYNC, clear OVERFLOW, WR_ADDR and the pixel counter.
REQ-011 SYNC: SHALL wait until FRAME_VALID=0, then move to WAIT_SOF; a frame already in progress SHALL never be captured.
REQ-012 WAIT_SOF: FRAME_VALID=1 SHALL move to CAPTURE in the same cycle that FRAME_VALID is sampled high.
REQ-013 CAPTURE: each cycle with FRAME_VALID=1 and LINE_VALID=1 SHALL register DATA_IN, then assert WR_EN with that data one cycle later (latency 1).
REQ-014 WR_ADDR SHALL hold the address of the current write and increment by 1 after each pixel slot, written or dropped, so frame geometry is preserved.
REQ-015 A pixel slot with WR_READY=0 SHALL be dropped (WR_EN=0); OVERFLOW SHALL set and stay set until the next START accepted in IDLE.
REQ-016 After H*V pixel slots, further pixels SHALL be dropped, WR_ADDR SHALL stay at H*V-1, and OVERFLOW SHALL set.
REQ-017 A FRAME_VALID 1->0 transition in CAPTURE SHALL pulse DONE one cycle after the final WR_EN and latch PIX_COUNT (written pixels only).
REQ-018 After DONE: with CONTINUOUS=1, SHALL go to WAIT_SOF with WR_ADDR=0 and OVERFLOW kept; otherwise SHALL go to IDLE.
REQ-019 A short frame (fewer than H*V slots) SHALL still produce DONE, with PIX_COUNT equal to the written count.
REQ-020 START outside IDLE SHALL be ignored.
REQ-021 ABORT SHALL force IDLE on the next edge from any state, suppress any pending WR_EN, and SHALL NOT pulse DONE; ABORT has priority over START.
REQ-022 BUSY SHALL be 1 in every state except IDLE.

Reset
REQ-023 RST SHALL force IDLE with WR_EN=0, WR_ADDR=0, WR_DATA=0, BUSY=0, DONE=0, OVERFLOW=0 and PIX_COUNT=0.
REQ-024 RST asserted mid-frame SHALL drop the partial frame; after release the block SHALL require START plus a full SYNC.

Configuration
REQ-025 With FRAME_CAPTURE_ROI_EN defined, SHALL add inputs ROI_X0, ROI_W ($clog2(H+1)) and ROI_Y0, ROI_H ($clog2(V+1)), latched at START.
REQ-026 With ROI enabled, only pixels with column in [X0, X0+W) and line in [Y0, Y0+H) SHALL count as slots; WR_ADDR SHALL be dense over the ROI; the saturation limit SHALL be W*H.
REQ-027 Without FRAME_CAPTURE_ROI_EN, the ROI ports SHALL be absent and the full frame SHALL be captured.

Structure
REQ-028 The state encoding and a WR_ADDR-width localparam function SHALL live in a shared package, camera_pkg.
REQ-029 The line and column positions SHALL be produced by instances of the existing counter sub-module (CLK/RST/EN/VALUE/MAXED).

Verification (H=8, V=4)
REQ-030 START during an active frame -> that frame is skipped; the next frame gives 32 WR_EN pulses with addresses 0..31 and DONE; PIX_COUNT=32.
REQ-031 WR_READY low for pixel slots 5 and 6 -> addresses 5 and 6 are skipped, 30 writes occur, OVERFLOW=1, PIX_COUNT=30.
REQ-032 CONTINUOUS=1 over 3 frames -> three DONE pulses, each frame writes addresses 0..31, BUSY stays 1.
REQ-033 ABORT at pixel 10 -> WR_EN low from the next cycle, state IDLE, no DONE; a new START captures normally.
REQ-034 Frame of 5 lines (40 slots) -> writes 0..31, WR_ADDR holds at 31, OVERFLOW=1, DONE pulses.
REQ-035 ROI enabled with X0=2, W=3, Y0=1, H=2 -> 6 writes at addresses 0..5 with the data of columns 2-4 on lines 1-2; PIX_COUNT=6.

Source files
------------

// File: rtl/camera_pkg.sv
// -----------------------------------------------------------------------------
// camera_pkg
// Shared definitions for the frame capture controller.
//   - cap_state_t : capture FSM state encoding
//   - PIX_W       : sensor pixel width
//   - addr_width  : frame-buffer address width for an h x v frame
// -----------------------------------------------------------------------------
package camera_pkg;

  localparam int PIX_W = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SYNC     = 2'd1,
    WAIT_SOF = 2'd2,
    CAPTURE  = 2'd3
  } cap_state_t;

  // Width of a frame-buffer address; never below one bit so a degenerate
  // 1x1 frame still yields a legal port.
  function automatic int addr_width(input int h, input int v);
    return (h * v > 1) ? $clog2(h * v) : 1;
  endfunction

endpackage

// File: rtl/frame_capture_ctrl_counter.sv
// -----------------------------------------------------------------------------
// frame_capture_ctrl_counter
// Position counter used for the column and line of the current pixel.
// Counts EN pulses from 0 up to MAX; at MAX it either wraps to 0 (WRAP=1)
// or holds (WRAP=0). CLR is a synchronous clear with priority over EN.
//
// Ports
//   CLK   : clock
//   RST   : asynchronous active-high reset
//   CLR   : synchronous clear to 0
//   EN    : count enable
//   VALUE : current count
//   MAXED : VALUE equals MAX
// -----------------------------------------------------------------------------
module frame_capture_ctrl_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 7,
  parameter bit WRAP  = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             EN,
  output logic [WIDTH-1:0] VALUE,
  output logic             MAXED
);

  logic [WIDTH-1:0] r_value;

  assign VALUE = r_value;
  assign MAXED = (r_value == WIDTH'(MAX));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, matching real flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_value <= '0;
    end else if (CLR) begin
      r_value <= '0;
    end else if (EN) begin
      if (MAXED) begin
        r_value <= WRAP ? '0 : r_value;
      end else begin
        r_value <= r_value + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// -----------------------------------------------------------------------------
// frame_capture_ctrl
// Captures one frame (or a continuous stream of frames) from a parallel
// camera sensor into a frame buffer write port. A capture is armed by START,
// waits for the sensor to be between frames (so a frame already in flight is
// never captured), then writes every pixel slot of the next frame.
//
// Optional build macro: FRAME_CAPTURE_ROI_EN adds a region-of-interest window
// latched at START; only pixels inside the window are slots and the write
// addresses are dense over the window.
//
// Ports
//   CLK, RST          : pixel clock, asynchronous active-high reset
//   FRAME_VALID       : sensor frame sync
//   LINE_VALID        : sensor line sync (pixel qualifier)
//   DATA_IN           : sensor pixel data
//   START             : arm a capture (accepted only in IDLE)
//   CONTINUOUS        : re-arm automatically after each frame
//   ABORT             : cancel, back to IDLE on the next edge (beats START)
//   ROI_X0/W, ROI_Y0/H: ROI window (FRAME_CAPTURE_ROI_EN builds only)
//   WR_EN/ADDR/DATA   : frame buffer write, one cycle after the pixel
//   WR_READY          : buffer can accept; sampled with the pixel, a slot
//                       seen with WR_READY=0 is dropped
//   BUSY              : not in IDLE
//   DONE              : one-cycle pulse at end of a captured frame
//   OVERFLOW          : sticky, a slot was dropped (cleared by START)
//   PIX_COUNT         : pixels written in the last completed frame
// -----------------------------------------------------------------------------
module frame_capture_ctrl
  import camera_pkg::*;
#(
  parameter  int H  = 752,
  parameter  int V  = 480,
  localparam int AW = addr_width(H, V),
  localparam int CW = $clog2(H * V + 1),
  localparam int XW = $clog2(H + 1),
  localparam int YW = $clog2(V + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FRAME_VALID,
  input  logic             LINE_VALID,
  input  logic [PIX_W-1:0] DATA_IN,
  input  logic             START,
  input  logic             CONTINUOUS,
  input  logic             ABORT,
`ifdef FRAME_CAPTURE_ROI_EN
  input  logic [XW-1:0]    ROI_X0,
  input  logic [XW-1:0]    ROI_W,
  input  logic [YW-1:0]    ROI_Y0,
  input  logic [YW-1:0]    ROI_H,
`endif
  output logic             WR_EN,
  output logic [AW-1:0]    WR_ADDR,
  output logic [PIX_W-1:0] WR_DATA,
  input  logic             WR_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVERFLOW,
  output logic [CW-1:0]    PIX_COUNT
);

  cap_state_t       r_state;
  cap_state_t       w_next_state;

  logic             w_start_ok;
  logic             w_frame_cycle;
  logic             w_pixel;
  logic             w_slot;
  logic             w_sat;
  logic             w_clr;
  logic             w_frame_end;
  logic [AW-1:0]    w_slot_addr;

  logic [XW-1:0]    w_col;
  logic             w_col_maxed;
  logic [YW-1:0]    w_line;
  logic             w_line_maxed;

  logic             r_wr_en;
  logic [AW-1:0]    r_wr_addr;
  logic [PIX_W-1:0] r_wr_data;
  logic             r_done;
  logic             r_overflow;
  logic [CW-1:0]    r_pix_count;
  logic [CW-1:0]    r_wr_cnt;

  assign w_start_ok = (r_state == IDLE) && START && !ABORT;

  // WAIT_SOF counts as part of the frame in the cycle FRAME_VALID is first
  // seen high, so a pixel arriving together with the frame start is kept.
  assign w_frame_cycle = !ABORT && FRAME_VALID &&
                         ((r_state == CAPTURE) || (r_state == WAIT_SOF));
  assign w_pixel       = w_frame_cycle && LINE_VALID;
  assign w_frame_end   = !ABORT && (r_state == CAPTURE) && !FRAME_VALID;
  assign w_clr         = !w_frame_cycle;

  // Column wraps every H pixels; line saturates at V so any extra lines of
  // an over-long frame sit outside the frame (and outside any ROI).
  frame_capture_ctrl_counter #(
    .WIDTH (XW),
    .MAX   (H - 1),
    .WRAP  (1'b1)
  ) u_col_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (w_clr),
    .EN    (w_pixel),
    .VALUE (w_col),
    .MAXED (w_col_maxed)
  );

  frame_capture_ctrl_counter #(
    .WIDTH (YW),
    .MAX   (V),
    .WRAP  (1'b0)
  ) u_line_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (w_clr),
    .EN    (w_pixel && w_col_maxed),
    .VALUE (w_line),
    .MAXED (w_line_maxed)
  );

`ifdef FRAME_CAPTURE_ROI_EN
  logic [XW-1:0] r_x0;
  logic [XW-1:0] r_w;
  logic [YW-1:0] r_y0;
  logic [YW-1:0] r_h;
  logic [CW-1:0] r_limit;
  logic [CW-1:0] r_roi_idx;
  logic          w_in_roi;

  // One extra bit on each side so X0+W / Y0+H cannot wrap.
  assign w_in_roi = !w_line_maxed &&
                    ({1'b0, w_col}  >= {1'b0, r_x0}) &&
                    ({1'b0, w_col}  <  ({1'b0, r_x0} + {1'b0, r_w})) &&
                    ({1'b0, w_line} >= {1'b0, r_y0}) &&
                    ({1'b0, w_line} <  ({1'b0, r_y0} + {1'b0, r_h}));

  assign w_slot      = w_pixel && w_in_roi;
  assign w_sat       = (r_roi_idx >= r_limit);
  assign w_slot_addr = r_roi_idx[AW-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_x0      <= '0;
      r_w       <= '0;
      r_y0      <= '0;
      r_h       <= '0;
      r_limit   <= '0;
      r_roi_idx <= '0;
    end else begin
      if (w_start_ok) begin
        r_x0    <= ROI_X0;
        r_w     <= ROI_W;
        r_y0    <= ROI_Y0;
        r_h     <= ROI_H;
        r_limit <= CW'(ROI_W) * CW'(ROI_H);
      end
      if (w_clr) begin
        r_roi_idx <= '0;
      end else if (w_slot && !w_sat) begin
        r_roi_idx <= r_roi_idx + 1'b1;
      end
    end
  end
`else
  // Full frame: every pixel is a slot and its address is its raster
  // position, so the slot limit is reached exactly when line V begins.
  assign w_slot      = w_pixel;
  assign w_sat       = w_line_maxed;
  assign w_slot_addr = AW'(w_line) * AW'(H) + AW'(w_col);
`endif

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment first guarantees every path drives
  // w_next_state, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (START)        w_next_state = SYNC;
      SYNC:     if (!FRAME_VALID) w_next_state = WAIT_SOF;
      WAIT_SOF: if (FRAME_VALID)  w_next_state = CAPTURE;
      CAPTURE:  if (!FRAME_VALID) w_next_state = CONTINUOUS ? WAIT_SOF : IDLE;
      default:                    w_next_state = IDLE;
    endcase
    if (ABORT) begin
      w_next_state = IDLE;
    end
  end

  // Write datapath, status and per-frame pixel accounting
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_pix_count <= '0;
      r_wr_cnt    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;

      if (w_start_ok) begin
        r_overflow <= 1'b0;
        r_wr_addr  <= '0;
      end

      if (w_clr) begin
        r_wr_cnt <= '0;
      end

      if (w_slot) begin
        if (w_sat) begin
          r_overflow <= 1'b1;
        end else begin
          // The address advances on every slot, written or not, so a
          // dropped pixel leaves a hole instead of shifting the image.
          r_wr_addr <= w_slot_addr;
          r_wr_data <= DATA_IN;
          r_wr_en   <= WR_READY;
          if (WR_READY) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
          end else begin
            r_overflow <= 1'b1;
          end
        end
      end

      // The frame-end cycle follows the last pixel, so its write is already
      // counted and DONE lands one cycle after the final WR_EN.
      if (w_frame_end) begin
        r_done      <= 1'b1;
        r_pix_count <= r_wr_cnt;
        if (CONTINUOUS) begin
          r_wr_addr <= '0;
        end
      end
    end
  end

  assign WR_EN     = r_wr_en;
  assign WR_ADDR   = r_wr_addr;
  assign WR_DATA   = r_wr_data;
  assign DONE      = r_done;
  assign OVERFLOW  = r_overflow;
  assign PIX_COUNT = r_pix_count;
  assign BUSY      = (r_state != IDLE);

endmodule
